matmul_addr_gen: RTL and testbench

//   Address sequencer directly upstream of the operand/result address registers and MAC datapath.
//   - Walks the triple loop C[i][j] += A[i][k]*B[k][j] for square NxN matrices.
//   - Emits one {A,B,C} address triple per beat on a valid/ready stream, with MAC clear/last flags.
//   - Handshakes with the controller via start/busy/done.

---
 rtl/matmul_pkg.sv | 16 +
 rtl/matmul_idx_counter.sv | 45 ++++
 rtl/matmul_addr_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_matmul_addr_gen.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply address generator.
//   DEF_WORD_SIZE : default address / base register width
//   DEF_DIM_W     : default width of the matrix dimension and loop indices
//   state_e       : sequencer states
package matmul_pkg;

    localparam int unsigned DEF_WORD_SIZE = 16;
    localparam int unsigned DEF_DIM_W     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/matmul_idx_counter.sv
// Loop index counter that wraps at a programmable limit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (wins over inc)
//   inc        : advance by one
//   limit      : wrap point; count runs 0 .. limit-1
//   count      : current index
//   wrap       : inc while count == limit-1 (count returns to zero)
module matmul_idx_counter
    import matmul_pkg::*;
#(
    parameter int unsigned DIM_W = DEF_DIM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [DIM_W-1:0] limit,
    output logic [DIM_W-1:0] count,
    output logic             wrap
);

    logic [DIM_W-1:0] count_q, count_d;

    assign wrap  = inc && (count_q == limit - DIM_W'(1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + DIM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/matmul_addr_gen.sv
// Address sequencer for C[i][j] += A[i][k] * B[k][j] over square NxN matrices.
// Emits one {A,B,C} address triple per beat (valid/ready) in i, j, k loop order
// (k innermost), with accumulator clear/last flags.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : start request, honoured only when idle
//   n_dim                 : matrix dimension N, latched on accepted start
//   base_a/base_b/base_c  : matrix base addresses, latched on accepted start
//   transpose_b           : (optional) B stored transposed, latched on start
//   addr_ready            : downstream accepts the current triple
//   addr_valid            : triple valid
//   addr_a/addr_b/addr_c  : base_a+i*N+k, base_b+k*N+j (or +j*N+k), base_c+i*N+j
//   mac_clear / mac_last  : k == 0 / k == N-1 while valid
//   busy                  : running or signalling done
//   done                  : one-cycle pulse after the final beat
// Build option: define MATMUL_ADDR_GEN_TRANSPOSE_B_EN to add the transpose_b port.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int unsigned word_size = DEF_WORD_SIZE,
    parameter int unsigned DIM_W     = DEF_DIM_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIM_W-1:0]     n_dim,
    input  logic [word_size-1:0] base_a,
    input  logic [word_size-1:0] base_b,
    input  logic [word_size-1:0] base_c,
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
    input  logic                 transpose_b,
`endif
    input  logic                 addr_ready,
    output logic                 addr_valid,
    output logic [word_size-1:0] addr_a,
    output logic [word_size-1:0] addr_b,
    output logic [word_size-1:0] addr_c,
    output logic                 mac_clear,
    output logic                 mac_last,
    output logic                 busy,
    output logic                 done
);

    state_e state_q, state_d;

    logic start_acc, beat;
    logic k_wrap, j_wrap, i_wrap;
    logic [DIM_W-1:0] k_cnt, j_cnt, i_cnt;

    logic [DIM_W-1:0]     n_q, n_d;
    logic [word_size-1:0] n_w;
    logic [word_size-1:0] base_b_q, base_b_d;
    // Row starts: a_row = base_a + i*N, c_row = base_c + i*N.
    logic [word_size-1:0] a_row_q, a_row_d, c_row_q, c_row_d;
    // Start of the current k-walk through B (k == 0 address for this j).
    logic [word_size-1:0] b_ref_q, b_ref_d;
    logic [word_size-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    // B strides: inner per k step, outer per j step.
    logic [word_size-1:0] b_step_inner, b_step_outer;

    assign n_w = word_size'(n_q);

`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
    logic transpose_q, transpose_d;

    assign b_step_inner = transpose_q ? word_size'(1) : n_w;
    assign b_step_outer = transpose_q ? n_w : word_size'(1);
`else
    assign b_step_inner = n_w;
    assign b_step_outer = word_size'(1);
`endif

    assign start_acc  = (state_q == IDLE) && start;
    assign addr_valid = (state_q == RUN);
    assign beat       = addr_valid && addr_ready;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // Flags are gated by valid so they read 0 in reset and between runs.
    assign mac_clear  = addr_valid && (k_cnt == '0);
    assign mac_last   = addr_valid && (k_cnt == n_q - DIM_W'(1));

    assign addr_a = addr_a_q;
    assign addr_b = addr_b_q;
    assign addr_c = addr_c_q;

    // Only the wrap of the outermost index matters; its count is not observed.
    logic unused_idx;
    assign unused_idx = ^{i_cnt, j_cnt};

    matmul_idx_counter #(
        .DIM_W (DIM_W)
    ) u_k_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .inc   (beat),
        .limit (n_q),
        .count (k_cnt),
        .wrap  (k_wrap)
    );

    matmul_idx_counter #(
        .DIM_W (DIM_W)
    ) u_j_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .inc   (k_wrap),
        .limit (n_q),
        .count (j_cnt),
        .wrap  (j_wrap)
    );

    matmul_idx_counter #(
        .DIM_W (DIM_W)
    ) u_i_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .inc   (j_wrap),
        .limit (n_q),
        .count (i_cnt),
        .wrap  (i_wrap)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (n_dim == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // i wraps only on the beat at i == j == k == N-1.
                if (i_wrap) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Incremental address update: only adds of 1 or N, never a multiply.
    always_comb begin
        n_d      = n_q;
        base_b_d = base_b_q;
        a_row_d  = a_row_q;
        c_row_d  = c_row_q;
        b_ref_d  = b_ref_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
        transpose_d = transpose_q;
`endif
        if (start_acc) begin
            n_d      = n_dim;
            base_b_d = base_b;
            a_row_d  = base_a;
            c_row_d  = base_c;
            b_ref_d  = base_b;
            addr_a_d = base_a;
            addr_b_d = base_b;
            addr_c_d = base_c;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
            transpose_d = transpose_b;
`endif
        end else if (beat) begin
            if (k_wrap && j_wrap) begin
                // Next row of A and C; B restarts at j == 0, k == 0.
                a_row_d  = a_row_q + n_w;
                c_row_d  = c_row_q + n_w;
                addr_a_d = a_row_q + n_w;
                addr_c_d = c_row_q + n_w;
                b_ref_d  = base_b_q;
                addr_b_d = base_b_q;
            end else if (k_wrap) begin
                // Next column of C; A rewinds to the row start.
                addr_a_d = a_row_q;
                addr_c_d = addr_c_q + word_size'(1);
                b_ref_d  = b_ref_q + b_step_outer;
                addr_b_d = b_ref_q + b_step_outer;
            end else begin
                addr_a_d = addr_a_q + word_size'(1);
                addr_b_d = addr_b_q + b_step_inner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q      <= '0;
            base_b_q <= '0;
            a_row_q  <= '0;
            c_row_q  <= '0;
            b_ref_q  <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
            transpose_q <= 1'b0;
`endif
        end else begin
            n_q      <= n_d;
            base_b_q <= base_b_d;
            a_row_q  <= a_row_d;
            c_row_q  <= c_row_d;
            b_ref_q  <= b_ref_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
            transpose_q <= transpose_d;
`endif
        end
    end

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Self-checking bench for matmul_addr_gen. Expected beat sequences come from
// nested i/j/k loops with plain multiplication, truncated to 16 bits.
module tb_matmul_addr_gen;
    import matmul_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        clr;
        logic        lst;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  n_dim = '0;
    logic [15:0] base_a = '0, base_b = '0, base_c = '0;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
    logic        transpose_b = 1'b0;
`endif
    logic        addr_ready = 1'b0;
    logic        addr_valid;
    logic [15:0] addr_a, addr_b, addr_c;
    logic        mac_clear, mac_last, busy, done;

    always #5 clk = ~clk;

    matmul_addr_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_dim      (n_dim),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_c     (base_c),
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
        .transpose_b(transpose_b),
`endif
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_c     (addr_c),
        .mac_clear  (mac_clear),
        .mac_last   (mac_last),
        .busy       (busy),
        .done       (done)
    );

    int    tests_run = 0;
    int    tests_failed = 0;
    beat_t exp_q[$];
    beat_t got_q[$];

    function automatic void build_model(input int n, input logic [15:0] ba, input logic [15:0] bb,
                                        input logic [15:0] bc, input logic tr);
        beat_t e;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                for (int k = 0; k < n; k++) begin
                    e.a   = ba + 16'(i * n + k);
                    e.b   = tr ? bb + 16'(j * n + k) : bb + 16'(k * n + j);
                    e.c   = bc + 16'(i * n + j);
                    e.clr = (k == 0);
                    e.lst = (k == n - 1);
                    exp_q.push_back(e);
                end
    endfunction

    function automatic logic pick_tr();
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // Starts a run and records every accepted beat into got_q.
    // Cycle numbering: the start-accepting edge is edge 0; cycle c is observed
    // at the falling edge after edge c. rmode: 0 ready high, 1 pattern 1-0-0-1,
    // 2 random. inj: cycle at which a stray start (n_dim=3) is driven, -1 none.
    task automatic run_op(input int n, input logic [15:0] ba, input logic [15:0] bb,
                          input logic [15:0] bc, input logic tr, input int rmode, input int inj,
                          output int done_cyc, output int last_beat, output int valid_seen,
                          output int errs);
        beat_t cur, prev;
        logic  stalled;
        logic  r;
        int    vcnt;
        got_q.delete();
        done_cyc = -1; last_beat = -1; valid_seen = 0; errs = 0;
        stalled = 1'b0; vcnt = 0; prev = '0;
        @(negedge clk);
        start = 1'b1; n_dim = 8'(n); base_a = ba; base_b = bb; base_c = bc;
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
        transpose_b = tr;
`endif
        @(negedge clk);
        for (int c = 1; c <= 4000; c++) begin
            // Scramble inputs after the latch; the run must not notice.
            start = (c == inj); n_dim = (c == inj) ? 8'd3 : 8'($urandom);
            base_a = 16'($urandom); base_b = 16'($urandom); base_c = 16'($urandom);
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
            transpose_b = ~tr;
`endif
            if (busy !== 1'b1) errs++;
            if (done === 1'b1) begin
                if (addr_valid !== 1'b0) errs++;
                done_cyc = c;
                break;
            end
            if (addr_valid === 1'b1) begin
                valid_seen++;
                cur = beat_t'({addr_a, addr_b, addr_c, mac_clear, mac_last});
                if (stalled && cur !== prev) errs++;
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (vcnt % 4 == 0) || (vcnt % 4 == 3);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                addr_ready = r;
                if (r) begin
                    got_q.push_back(cur);
                    last_beat = c;
                end
                stalled = !r;
                prev = cur;
            end else begin
                addr_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0; addr_ready = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0 || addr_valid !== 1'b0) errs++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({addr_valid, addr_a, addr_b, addr_c, mac_clear, mac_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 0",
                     {addr_valid, addr_a, addr_b, addr_c, mac_clear, mac_last, busy, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int dc, lb, vs, er;
        beat_t want;
        want = '{a: 16'h10, b: 16'h20, c: 16'h30, clr: 1'b1, lst: 1'b1};
        run_op(1, 16'h10, 16'h20, 16'h30, 1'b0, 0, -1, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL single_count: got %0d beats want 1", got_q.size());
        end else begin
            tests_run++;
            if (got_q[0] !== want) begin
                tests_failed++;
                $display("FAIL single_beat: got %h want %h", got_q[0], want);
            end
        end
        // Start cycle, valid cycle, done cycle: done two edges after acceptance.
        tests_run++;
        if (dc != 2) begin
            tests_failed++;
            $display("FAIL single_done_cycle: got %0d want 2", dc);
        end
        tests_run++;
        if (er != 0) begin
            tests_failed++;
            $display("FAIL single_protocol: got %0d errors want 0", er);
        end
    endtask

    task automatic test_n2();
        int dc, lb, vs, er;
        beat_t want;
        want = '{a: 16'h001, b: 16'h103, c: 16'h201, clr: 1'b0, lst: 1'b1};
        build_model(2, 16'h0, 16'h100, 16'h200, 1'b0);
        run_op(2, 16'h0, 16'h100, 16'h200, 1'b0, 0, -1, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != 8) begin
            tests_failed++;
            $display("FAIL n2_count: got %0d want 8", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL n2_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() > 3) begin
            tests_run++;
            if (got_q[3] !== want) begin
                tests_failed++;
                $display("FAIL n2_beat3_const: got %h want %h", got_q[3], want);
            end
        end
        tests_run++;
        if (dc != 9 || er != 0) begin
            tests_failed++;
            $display("FAIL n2_done: got cycle %0d errs %0d want 9 / 0", dc, er);
        end
    endtask

    task automatic test_backpressure();
        int dc, lb, vs, er;
        build_model(2, 16'h0, 16'h100, 16'h200, 1'b0);
        run_op(2, 16'h0, 16'h100, 16'h200, 1'b0, 1, -1, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (dc != lb + 1 || dc < 0) begin
            tests_failed++;
            $display("FAIL bp_done: got cycle %0d want %0d", dc, lb + 1);
        end
        tests_run++;
        if (er != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d errors want 0", er);
        end
    endtask

    task automatic test_start_ignored();
        int dc, lb, vs, er;
        logic [15:0] ba, bb, bc;
        ba = 16'($urandom); bb = 16'($urandom); bc = 16'($urandom);
        build_model(2, ba, bb, bc, 1'b0);
        run_op(2, ba, bb, bc, 1'b0, 0, 3, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != 8 || dc != 9 || er != 0) begin
            tests_failed++;
            $display("FAIL restart_ignored: got %0d beats done %0d errs %0d want 8 / 9 / 0",
                     got_q.size(), dc, er);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL restart_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        int dc, lb, vs, er, beats;
        logic seen_done;
        logic [15:0] ba, bb, bc;
        ba = 16'($urandom); bb = 16'($urandom); bc = 16'($urandom);
        build_model(3, ba, bb, bc, 1'b0);
        @(negedge clk);
        start = 1'b1; n_dim = 8'd3; base_a = ba; base_b = bb; base_c = bc;
        @(negedge clk);
        start = 1'b0; addr_ready = 1'b1; beats = 0;
        for (int c = 0; c < 100; c++) begin
            if (addr_valid === 1'b1 && beats == 3) break;
            if (addr_valid === 1'b1) beats++;
            @(negedge clk);
        end
        tests_run++;
        if (beats != 3 || beat_t'({addr_a, addr_b, addr_c, mac_clear, mac_last}) !== exp_q[3]) begin
            tests_failed++;
            $display("FAIL abort_beat4: got %0d beats, %h want 3, %h", beats,
                     beat_t'({addr_a, addr_b, addr_c, mac_clear, mac_last}), exp_q[3]);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({addr_valid, addr_a, addr_b, addr_c, mac_clear, mac_last, busy, done} !== '0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got %h want 0",
                     {addr_valid, addr_a, addr_b, addr_c, mac_clear, mac_last, busy, done});
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        addr_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done) begin
            tests_failed++;
            $display("FAIL abort_no_done: got done=1 want 0");
        end
        ba = 16'($urandom); bb = 16'($urandom); bc = 16'($urandom);
        build_model(2, ba, bb, bc, 1'b0);
        run_op(2, ba, bb, bc, 1'b0, 0, -1, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != 8 || dc != 9 || er != 0) begin
            tests_failed++;
            $display("FAIL abort_rerun: got %0d beats done %0d errs %0d want 8 / 9 / 0",
                     got_q.size(), dc, er);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL abort_rerun_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_dim();
        int dc, lb, vs, er;
        run_op(0, 16'h1234, 16'h5678, 16'h9abc, 1'b0, 2, -1, dc, lb, vs, er);
        tests_run++;
        if (vs != 0 || got_q.size() != 0) begin
            tests_failed++;
            $display("FAIL zero_no_valid: got %0d valid cycles want 0", vs);
        end
        tests_run++;
        if (dc != 1 || er != 0) begin
            tests_failed++;
            $display("FAIL zero_done: got cycle %0d errs %0d want 1 / 0", dc, er);
        end
    endtask

`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
    task automatic test_transpose();
        int dc, lb, vs, er;
        logic [15:0] ba, bb, bc, want_b;
        ba = 16'($urandom); bb = 16'($urandom); bc = 16'($urandom);
        want_b = bb + 16'd2;
        build_model(2, ba, bb, bc, 1'b1);
        run_op(2, ba, bb, bc, 1'b1, 0, -1, dc, lb, vs, er);
        tests_run++;
        if (got_q.size() != 8 || got_q[2].b !== want_b) begin
            tests_failed++;
            $display("FAIL transpose_b_i0j1k0: got %0d beats, %h want 8, %h",
                     got_q.size(), got_q.size() > 2 ? got_q[2].b : 16'h0, want_b);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL transpose_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int dc, lb, vs, er, n;
        logic [15:0] ba, bb, bc;
        logic tr;
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(1, 5);
            // Bases near the top of the address space exercise wrap-around.
            ba = (it % 2 == 0) ? 16'($urandom_range(16'hffe0, 16'hffff)) : 16'($urandom);
            bb = 16'($urandom);
            bc = (it % 3 == 0) ? 16'hfffe : 16'($urandom);
            tr = pick_tr();
            build_model(n, ba, bb, bc, tr);
            run_op(n, ba, bb, bc, tr, 2, -1, dc, lb, vs, er);
            tests_run++;
            if (got_q.size() != n * n * n || er != 0 || dc != lb + 1) begin
                tests_failed++;
                $display("FAIL rand%0d_run: got %0d beats errs %0d done %0d want %0d / 0 / %0d",
                         it, got_q.size(), er, dc, n * n * n, lb + 1);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                tests_run++;
                if (got_q[i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_n2();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_zero_dim();
`ifdef MATMUL_ADDR_GEN_TRANSPOSE_B_EN
        test_transpose();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
